sseg_scan: RTL and testbench
============================

# sseg_scan

Time-multiplexed seven-segment display driver with a parametrised digit count. It scans DIGITS hex digits onto one shared segment bus and a one-hot digit-select bus. A frame-synchronous shadow register prevents tearing, and an inter-digit blanking gap suppresses ghosting. It sits between the application's display-value registers and the board's anode/cathode pins, and replaces the static 64-bit all-digits decode path.

## Interface
- DIGITS, 8: number of digits scanned; 2..16.
- SCAN_DIV, 100000: clock cycles per digit slot; ≥ 4.
- BLANK_CYC, 2: cycles at the start of each slot with all digits deselected; 1 ≤ BLANK_CYC < SCAN_DIV.
- ACTIVE_LOW, 1: 1 = `an` and `seg` are active-low (lit = 0); 0 = active-high.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- data  in  4*DIGITS  hex nibbles; digit k = data[4k+3:4k]; digit 0 is least significant.
- dp  in  DIGITS  decimal point per digit.
- load  in  1  one-cycle strobe; captures data/dp into the pending register.
- an  out  DIGITS  one-hot digit select, polarity per ACTIVE_LOW.
- seg  out  8  bit7 = dp, bit6..0 = a,b,c,d,e,f,g; polarity per ACTIVE_LOW.
- frame_start  out  1  one-cycle pulse when digit 0's slot begins.

## Operation
- Registers: prescaler `pcnt` (0..SCAN_DIV-1), digit index `idx` (0..DIGITS-1), pending {data,dp} plus `pend` flag, shadow {data,dp}.
- `pcnt` increments each cycle. At SCAN_DIV-1 it wraps to 0 and `idx` advances; `idx` wraps DIGITS-1 → 0.
- Frame boundary is `pcnt == SCAN_DIV-1 && idx == DIGITS-1`.
  - If `pend`, pending is copied to shadow and `pend` is cleared.
  - If `load` is asserted in that same cycle, the value on the `data`/`dp` inputs is written straight to shadow, and `pend` stays 0.
- `load` at any other time overwrites pending and sets `pend`. Only the last load before a boundary takes effect.
- Decode (active-high form, bits 6..0 = a..g), nibble 0..F → 7E 30 6D 79 33 5B 5F 70 7F 7B 77 1F 4E 3D 4F 47. Bit7 = shadow dp[idx].
- Slot output:
  - While `pcnt < BLANK_CYC`: all digits deselected and all segments off.
  - Otherwise: an[idx] is selected and `seg` carries the decode of shadow digit idx.
- Polarity: when ACTIVE_LOW = 1, both `an` and `seg` are inverted at the output register.
- Changes to `data` without `load` never affect the display.

## Timing
- Reset values: pcnt = 0, idx = 0, shadow = 0, pending = 0, pend = 0, frame_start = 0.
  - `an` = all deselected (all 1 if ACTIVE_LOW, else all 0).
  - `seg` = all off (8'hFF if ACTIVE_LOW, else 8'h00).
- Outputs are registered and lag pcnt/idx by exactly 1 cycle.
  - After reset release, the first cycle with a digit selected is cycle BLANK_CYC+1.
- frame_start is asserted in the cycle when the `an` output register first reflects idx = 0 slot start (pcnt = 0 registered).
  - It is not asserted in the first slot after reset.
- Frame period = DIGITS × SCAN_DIV cycles. Each digit is lit for SCAN_DIV − BLANK_CYC cycles per frame.
- Load-to-display latency: the value appears from the first slot of the next frame, at most DIGITS × SCAN_DIV + 1 cycles.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronously), and any pending load is discarded.

## Configuration
- SSEG_LZB_EN defined: leading-zero blanking.
  - A digit k > 0 is blanked (segments off, including dp) when it and every higher digit in the shadow are 0 and none of their dp bits are set.
  - Digit 0 is never blanked. `an` scanning is unchanged.
- SSEG_LZB_EN undefined: every digit displays its decode, including leading zeros.

## Test plan
All scenarios use DIGITS=4, SCAN_DIV=8, BLANK_CYC=2, ACTIVE_LOW=0.

- Reset then run 40 cycles with no load:
  - `an` = 0000 and `seg` = 00 through cycle 2.
  - Then an = 0001 and seg = 7E for 6 cycles, followed by a 2-cycle gap of an = 0000, then an = 0010.
- Load data=16'h1234, dp=4'b0100 mid-frame:
  - The current frame still shows 0.
  - Next frame shows digit0 = 33, digit1 = 79, digit2 = ED (dp set), digit3 = 30.
- Two loads in one frame (16'hAAAA, then 16'h5B5B): only 5B5B is displayed. Load coincident with the frame boundary: the value is shown in the immediately following frame.
- Load 16'h0007 with SSEG_LZB_EN:
  - Digits 3..1 give seg = 00 while their `an` is still selected; digit0 gives seg = 70.
  - Without the macro, digits 3..1 give seg = 7E.
- ACTIVE_LOW=1, data 16'h8888: selected an bit = 0, seg = 80 in lit phases; blank phases give an = 1111, seg = FF.
- Assert rst_n low mid-slot with a pending load: outputs return to reset values in the same cycle, and the pending value is never displayed after release.

Source files
------------

// File: rtl/sseg_scan_if.sv
// sseg_scan_if: display-value load port and scanned anode/segment outputs of sseg_scan.
interface sseg_scan_if #(parameter int DIGITS = 8);
    logic [4*DIGITS-1:0] data;
    logic [DIGITS-1:0]   dp;
    logic                load;
    logic [DIGITS-1:0]   an;
    logic [7:0]          seg;
    logic                frame_start;
    modport master (output data, dp, load, input an, seg, frame_start);
    modport slave  (input data, dp, load, output an, seg, frame_start);
endinterface

// File: rtl/sseg_scan.sv
// sseg_scan: time-multiplexed seven-segment driver with frame-synchronous shadow and blanking gap.
// Define SSEG_LZB_EN to enable leading-zero blanking.
module sseg_scan #(
    parameter int DIGITS     = 8,
    parameter int SCAN_DIV   = 100000,
    parameter int BLANK_CYC  = 2,
    parameter int ACTIVE_LOW = 1
) (
    input  logic clk,
    input  logic rst_n,
    sseg_scan_if.slave bus
);
    localparam int   PW  = $clog2(SCAN_DIV);
    localparam int   IW  = $clog2(DIGITS);
    localparam logic POL = (ACTIVE_LOW != 0);
    localparam logic [111:0] LUT = {7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
                                    7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E};

    logic [PW-1:0]       pcnt_q, pcnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] pdata_q, pdata_d, sdata_q, sdata_d;
    logic [DIGITS-1:0]   pdp_q, pdp_d, sdp_q, sdp_d;
    logic                pend_q, pend_d, run_q, run_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [7:0]          seg_q, seg_d;
    logic                fs_q, fs_d;
    logic                wrap, frame, blank, lz_blank;
    logic [3:0]          nib;

`ifdef SSEG_LZB_EN
    logic [DIGITS-1:0] lz;
    // lz[k]: digit k and every digit above it are zero with no dp set
    for (genvar k = 0; k < DIGITS; k++) begin : g_lz
        if (k == DIGITS-1) begin : g_top
            assign lz[k] = sdata_q[4*k +: 4] == 4'h0 && !sdp_q[k];
        end else begin : g_low
            assign lz[k] = sdata_q[4*k +: 4] == 4'h0 && !sdp_q[k] && lz[k+1];
        end
    end
`endif

    always_comb begin
        wrap    = pcnt_q == PW'(SCAN_DIV-1);
        frame   = wrap && idx_q == IW'(DIGITS-1);
        pcnt_d  = wrap ? '0 : pcnt_q + 1'b1;
        idx_d   = wrap ? (frame ? '0 : idx_q + 1'b1) : idx_q;
        pend_d  = frame ? 1'b0 : (bus.load | pend_q);
        pdata_d = (bus.load && !frame) ? bus.data : pdata_q;
        pdp_d   = (bus.load && !frame) ? bus.dp : pdp_q;
        // a load on the boundary itself bypasses pending and wins over it
        sdata_d = frame ? (bus.load ? bus.data : (pend_q ? pdata_q : sdata_q)) : sdata_q;
        sdp_d   = frame ? (bus.load ? bus.dp : (pend_q ? pdp_q : sdp_q)) : sdp_q;
        run_d   = run_q | frame;
        nib     = sdata_q[idx_q*4 +: 4];
        blank   = pcnt_q < PW'(BLANK_CYC);
`ifdef SSEG_LZB_EN
        lz_blank = idx_q != '0 && lz[idx_q];
`else
        lz_blank = 1'b0;
`endif
        an_d  = (blank ? '0 : DIGITS'(1) << idx_q) ^ {DIGITS{POL}};
        seg_d = ((blank || lz_blank) ? 8'h00 : {sdp_q[idx_q], LUT[nib*7 +: 7]}) ^ {8{POL}};
        fs_d  = run_q && pcnt_q == '0 && idx_q == '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q  <= '0;
            idx_q   <= '0;
            pdata_q <= '0;
            pdp_q   <= '0;
            sdata_q <= '0;
            sdp_q   <= '0;
            pend_q  <= 1'b0;
            run_q   <= 1'b0;
            an_q    <= {DIGITS{POL}};
            seg_q   <= {8{POL}};
            fs_q    <= 1'b0;
        end else begin
            pcnt_q  <= pcnt_d;
            idx_q   <= idx_d;
            pdata_q <= pdata_d;
            pdp_q   <= pdp_d;
            sdata_q <= sdata_d;
            sdp_q   <= sdp_d;
            pend_q  <= pend_d;
            run_q   <= run_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            fs_q    <= fs_d;
        end
    end

    assign bus.an          = an_q;
    assign bus.seg         = seg_q;
    assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_sseg_scan.sv
// tb_sseg_scan: scoreboard bench for sseg_scan, active-high and active-low instances on shared stimulus.
module tb_sseg_scan;
    localparam int D = 4, SD = 8, BC = 2;

    typedef struct {
        logic [3:0] an;
        logic [7:0] seg;
        logic       fs;
    } exp_t;

    logic clk = 0, rst_n = 1, load = 0;
    logic [15:0] data = 0;
    logic [3:0]  dp = 0;
    int errors = 0, checks = 0, n = 0;
    logic [15:0] latest_d, shown_d;
    logic [3:0]  latest_p, shown_p;
    exp_t q[$];
    logic [6:0] lut [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    always #5 clk = ~clk;

    sseg_scan_if #(.DIGITS(D)) if0 ();
    sseg_scan_if #(.DIGITS(D)) if1 ();
    assign if0.data = data;
    assign if0.dp   = dp;
    assign if0.load = load;
    assign if1.data = data;
    assign if1.dp   = dp;
    assign if1.load = load;

    sseg_scan #(.DIGITS(D), .SCAN_DIV(SD), .BLANK_CYC(BC), .ACTIVE_LOW(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    sseg_scan #(.DIGITS(D), .SCAN_DIV(SD), .BLANK_CYC(BC), .ACTIVE_LOW(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference: frame F shows the latest load made before frame F begins.
    always @(posedge clk) begin
        int pc, ix;
        exp_t e;
        if (!rst_n) begin
            n = 0;
            latest_d = 0; latest_p = 0; shown_d = 0; shown_p = 0;
        end else begin
            pc = n % SD;
            ix = (n / SD) % D;
            if (n % (SD*D) == 0) begin
                shown_d = latest_d;
                shown_p = latest_p;
            end
            e.fs = (n % (SD*D) == 0) && n > 0;
            if (pc < BC) begin
                e.an = 4'h0;
                e.seg = 8'h00;
            end else begin
                e.an = 4'(1 << ix);
                e.seg = {shown_p[ix], lut[shown_d[ix*4 +: 4]]};
`ifdef SSEG_LZB_EN
                if (ix > 0 && (shown_d >> (4*ix)) == 0 && (shown_p >> ix) == 0) e.seg = 8'h00;
`endif
            end
            q.push_back(e);
            if (load) begin
                latest_d = data;
                latest_p = dp;
            end
            n++;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && q.size() > 0) begin
            e = q.pop_front();
            chk("an0", {4'h0, if0.an}, {4'h0, e.an});
            chk("seg0", if0.seg, e.seg);
            chk("fs0", {7'h0, if0.frame_start}, {7'h0, e.fs});
            chk("an1", {4'h0, if1.an}, {4'h0, ~e.an});
            chk("seg1", if1.seg, ~e.seg);
            chk("fs1", {7'h0, if1.frame_start}, {7'h0, e.fs});
        end
    end

    task automatic chk_reset();
        chk("rst_an0", {4'h0, if0.an}, 8'h00);
        chk("rst_seg0", if0.seg, 8'h00);
        chk("rst_fs0", {7'h0, if0.frame_start}, 8'h00);
        chk("rst_an1", {4'h0, if1.an}, 8'h0F);
        chk("rst_seg1", if1.seg, 8'hFF);
        chk("rst_fs1", {7'h0, if1.frame_start}, 8'h00);
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            data = 16'($urandom);
            dp = 4'($urandom);
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p);
        data = d;
        dp = p;
        load = 1;
        @(posedge clk);
        #2;
        load = 0;
    endtask

    initial begin
        #1 rst_n = 0;
        #1 chk_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        idle(40);
        do_load(16'h1234, 4'b0100);
        idle(70);
        do_load(16'hAAAA, 4'b0000);
        idle(3);
        do_load(16'h5B5B, 4'b0000);
        idle(70);
        for (int i = 0; i < 64 && n % (SD*D) != SD*D-1; i++) idle(1);
        chk("boundary_wait", 8'(n % (SD*D)), 8'(SD*D-1));
        do_load(16'h9C3E, 4'b1001);
        idle(40);
        do_load(16'h0007, 4'b0000);
        idle(70);
        do_load(16'h8888, 4'b0000);
        idle(70);
        repeat (20) begin
            do_load(16'($urandom) >> (4*$urandom_range(0, 3)), 4'($urandom) & 4'($urandom));
            idle($urandom_range(1, 40));
        end
        do_load(16'hBEEF, 4'hF);
        idle(3);
        rst_n = 0;
        #1 chk_reset();
        q.delete();
        @(posedge clk);
        #2 rst_n = 1;
        idle(80);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
